// File: rtl/code2421_pkg.sv
// Shared constants and helpers for the 2421 (Aiken) seven-segment scanner.
package code2421_pkg;

   localparam int unsigned SEG_W = 7;

   // Patterns are {g,f,e,d,c,b,a}, active-high
   localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   // Legal codes are 0000..0100 and 1011..1111
   function automatic logic is_valid_2421(input logic [3:0] code);
      return (code <= 4'd4) || (code >= 4'd11);
   endfunction

   // Upper half of the code space sits 6 above its decimal value
   function automatic logic [3:0] dec_2421(input logic [3:0] code);
      return code[3] ? 4'(code - 4'd6) : code;
   endfunction

endpackage

// File: rtl/code2421_to_seg.sv
// Combinational 2421 code to seven-segment decoder with validity flag.
module code2421_to_seg
   import code2421_pkg::*;
(
   input  logic [3:0]       code_i,
   output logic [SEG_W-1:0] seg_c,
   output logic             valid_c
);

   logic [3:0] value;

   always_comb begin
      valid_c = is_valid_2421(code_i);
      value   = dec_2421(code_i);
      seg_c   = SEG_DASH;
      if (valid_c) begin
         case (value)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/code2421_seg_scan.sv
// Captures DIGITS 2421 digits, flags invalid codes and scans them onto one segment bus.
// Optional leading-zero blanking: define CODE2421_LEADING_BLANK_EN.
module code2421_seg_scan
   import code2421_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned PRESCALE = 50000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [4*DIGITS-1:0] digits_in,
   input  logic                err_clr,
   output logic [SEG_W-1:0]    seg,
   output logic [DIGITS-1:0]   an,
   output logic [DIGITS-1:0]   digit_err
);

   localparam int unsigned IDX_W = $clog2(DIGITS);
   localparam int unsigned CNT_W = $clog2(PRESCALE);

   logic [4*DIGITS-1:0] cap_q, cap_d;
   logic [DIGITS-1:0]   err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [SEG_W-1:0]    seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic                tick;
   logic [3:0]          cur_code;
   logic [SEG_W-1:0]    cur_seg_c;
   logic                cur_valid_c;

   code2421_to_seg u_to_seg (
      .code_i  (cur_code),
      .seg_c   (cur_seg_c),
      .valid_c (cur_valid_c)
   );

   // Capture, sticky error flags (set beats clear per digit) and prescaler
   always_comb begin
      cap_d = cap_q;
      err_d = err_clr ? '0 : err_q;
      if (load) begin
         cap_d = digits_in;
         for (int i = 0; i < int'(DIGITS); i++) begin
            if (!is_valid_2421(digits_in[4*i +: 4])) err_d[i] = 1'b1;
         end
      end
      tick  = (cnt_q == CNT_W'(PRESCALE - 1));
      cnt_d = tick ? '0 : CNT_W'(cnt_q + 1'b1);
   end

`ifdef CODE2421_LEADING_BLANK_EN
   logic [DIGITS-1:0] blank;

   // Zero run from the most significant digit down; digit 0 always shows
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      blank    = '0;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         zero_run = zero_run && (cap_q[4*i +: 4] == 4'd0);
         blank[i] = zero_run;
      end
   end
`endif

   // Scan: the tick shows the digit held before any same-cycle load
   always_comb begin
      cur_code = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IDX_W'(i)) cur_code = cap_q[4*i +: 4];
      end
      seg_d = seg_q;
      an_d  = an_q;
      idx_d = idx_q;
      if (tick) begin
         seg_d = cur_valid_c ? cur_seg_c : SEG_DASH;
`ifdef CODE2421_LEADING_BLANK_EN
         for (int i = 0; i < int'(DIGITS); i++) begin
            if ((idx_q == IDX_W'(i)) && blank[i]) seg_d = SEG_BLANK;
         end
`endif
         for (int i = 0; i < int'(DIGITS); i++) begin
            an_d[i] = (idx_q == IDX_W'(i));
         end
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : IDX_W'(idx_q + 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q <= '0;
         err_q <= '0;
         cnt_q <= '0;
         idx_q <= '0;
         seg_q <= '0;
         an_q  <= '0;
      end else begin
         cap_q <= cap_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign digit_err = err_q;

endmodule

// File: tb/tb_code2421_seg_scan.sv
// Directed bench for code2421_seg_scan with DIGITS=4, PRESCALE=4.
// Leading-blank expectations follow CODE2421_LEADING_BLANK_EN.
module tb_code2421_seg_scan;

   localparam int unsigned DIGITS   = 4;
   localparam int unsigned PRESCALE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] digits_in;
   logic        err_clr;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [3:0]  digit_err;

   int n_checks = 0;
   int n_fails  = 0;

   code2421_seg_scan #(
      .DIGITS   (DIGITS),
      .PRESCALE (PRESCALE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .digits_in (digits_in),
      .err_clr   (err_clr),
      .seg       (seg),
      .an        (an),
      .digit_err (digit_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n cycles; inputs change and outputs are sampled on the falling edge
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic slot(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
      check({tag, "_an"}, 32'(an), 32'(exp_an));
      check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; digits_in = '0; err_clr = 1'b0;
      step(2);
      check("rst_seg", 32'(seg), 32'h0);
      check("rst_an", 32'(an), 32'h0);
      check("rst_err", 32'(digit_err), 32'h0);

      // Basic scan of 9,7,5,0
      rst = 1'b0; load = 1'b1; digits_in = 16'hFDB0;
      step(1);
      load = 1'b0;
      check("load_err", 32'(digit_err), 32'h0);
      step(3);
      slot("scan_d0", 4'b0001, 7'b0111111);
      step(1);
      slot("hold_d0", 4'b0001, 7'b0111111);
      step(3);
      slot("scan_d1", 4'b0010, 7'b1101101);
      step(4);
      slot("scan_d2", 4'b0100, 7'b0000111);
      step(4);
      slot("scan_d3", 4'b1000, 7'b1101111);
      step(4);
      slot("scan_wrap", 4'b0001, 7'b0111111);

      // Invalid digit 2 (0110): sticky flag and dash
      load = 1'b1; digits_in = 16'h1623;
      step(1);
      load = 1'b0;
      check("inv_err", 32'(digit_err), 32'h4);
      step(3);
      slot("inv_d1", 4'b0010, 7'b1011011);
      step(4);
      slot("inv_d2", 4'b0100, 7'b1000000);
      step(4);
      slot("inv_d3", 4'b1000, 7'b0000110);
      load = 1'b1; digits_in = 16'h1234;
      step(1);
      load = 1'b0;
      check("sticky_err", 32'(digit_err), 32'h4);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("clr_err", 32'(digit_err), 32'h0);
      step(2);
      slot("new_d0", 4'b0001, 7'b1100110);

      // Load coinciding with tick: old digit 1 (3) shows, then new digit 2 (9)
      step(3);
      load = 1'b1; digits_in = 16'hFFFF;
      step(1);
      load = 1'b0;
      slot("coinc_old", 4'b0010, 7'b1001111);
      step(4);
      slot("coinc_new", 4'b0100, 7'b1101111);

      // Set beats clear on the loaded invalid digit only
      load = 1'b1; digits_in = 16'h8FFF;
      step(1);
      check("err_d3", 32'(digit_err), 32'h8);
      digits_in = 16'hFF5F; err_clr = 1'b1;
      step(1);
      load = 1'b0; err_clr = 1'b0;
      check("set_wins", 32'(digit_err), 32'h2);
      step(2);
      slot("after_d3", 4'b1000, 7'b1101111);
      step(4);
      slot("after_d0", 4'b0001, 7'b1101111);
      step(4);
      slot("after_d1", 4'b0010, 7'b1000000);
      step(4);
      slot("after_d2", 4'b0100, 7'b1101111);

      // Reset in the digit 2 slot
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      slot("midrst", 4'b0000, 7'b0000000);
      check("midrst_err", 32'(digit_err), 32'h0);
      step(3);
      slot("prerel", 4'b0000, 7'b0000000);
      step(1);
      slot("postrel_d0", 4'b0001, 7'b0111111);

      // Leading-zero digits 0000,0000,0011,0000
      load = 1'b1; digits_in = 16'h0030;
      step(1);
      load = 1'b0;
      step(3);
      slot("lz_d1", 4'b0010, 7'b1001111);
`ifdef CODE2421_LEADING_BLANK_EN
      step(4);
      slot("lz_d2", 4'b0100, 7'b0000000);
      step(4);
      slot("lz_d3", 4'b1000, 7'b0000000);
`else
      step(4);
      slot("lz_d2", 4'b0100, 7'b0111111);
      step(4);
      slot("lz_d3", 4'b1000, 7'b0111111);
`endif
      step(4);
      slot("lz_d0", 4'b0001, 7'b0111111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
